// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply / divide unit: 32-cycle shift-add multiply
// and 32-cycle restoring divide on operand magnitudes with final sign fix-up.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        MultOrDiv,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        ErroDiv
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opb_q, opb_d;
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            err_q, err_d;

  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next, mul_res;
  logic [W:0]      div_shift, div_trial;
  logic [2*W-1:0]  div_next;
  logic [W-1:0]    quo_res, rem_res;

  // Datapath for one iteration; acc holds {partial product} or {remainder, quotient}
  always_comb begin
    a_mag     = A[W-1] ? W'(~A + W'(1)) : A;
    b_mag     = B[W-1] ? W'(~B + W'(1)) : B;
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : (W+1)'(0));
    mul_next  = {mul_sum, acc_q[W-1:1]};
    mul_res   = neg_q ? (2*W)'(~mul_next + (2*W)'(1)) : mul_next;
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_trial = div_shift - {1'b0, opb_q};
    div_next  = div_trial[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                             : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
    quo_res   = neg_q ? W'(~div_next[W-1:0] + W'(1)) : div_next[W-1:0];
    rem_res   = neg_rem_q ? W'(~div_next[2*W-1:W] + W'(1)) : div_next[2*W-1:W];
  end

  // Next-state and register updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          cnt_d     = '0;
          err_d     = 1'b0;
          acc_d     = {W'(0), a_mag};
          opb_d     = b_mag;
          neg_d     = A[W-1] ^ B[W-1];
          neg_rem_d = A[W-1];
          if (!MultOrDiv) begin
            state_d = MULT;
          end else if (B == '0) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            state_d = DIV;
          end
        end
      end
      MULT: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          {hi_d, lo_d} = mul_res;
          state_d      = FINISH;
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          hi_d    = rem_res;
          lo_d    = quo_res;
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      err_q     <= err_d;
    end
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign ErroDiv = err_q;
  assign Busy    = (state_q != IDLE);
  assign Done    = (state_q == FINISH);

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 Start  in  1  request from ctrl_unit; sampled only in IDLE.
REQ-004 MultOrDiv  in  1  operation select: 0 = signed multiply, 1 = signed divide; captured with Start.
REQ-005 A  in  32  multiplicand or dividend; captured with Start.
REQ-006 B  in  32  multiplier or divisor; captured with Start.
REQ-007 Hi  out  32  result register: product[63:32] or remainder.
REQ-008 Lo  out  32  result register: product[31:0] or quotient.
REQ-009 Busy  out  1  high while an operation is in progress (MULT, DIV, FINISH).
REQ-010 Done  out  1  one-cycle completion pulse.
REQ-011 ErroDiv  out  1  divide-by-zero flag.

Function
REQ-012 FSM states SHALL be IDLE, MULT, DIV, FINISH.
REQ-013 IDLE with Start=1 SHALL capture A, B and MultOrDiv, clear ErroDiv and the 5-bit iteration counter, and go to MULT (MultOrDiv=0) or DIV (MultOrDiv=1).
REQ-014 IDLE with Start=1, MultOrDiv=1 and B=0 SHALL go directly to FINISH with ErroDiv=1; Hi and Lo SHALL stay unchanged.
REQ-015 MULT SHALL run exactly 32 iteration cycles (signed shift-add or radix-2 Booth) and then go to FINISH.
REQ-016 DIV SHALL run exactly 32 restoring iteration cycles on the operand magnitudes, apply sign correction, and then go to FINISH.
REQ-017 Hi and Lo SHALL update only on the edge that enters FINISH from MULT or DIV.
REQ-018 FINISH SHALL last one cycle with Done=1, then return to IDLE.
REQ-019 Latency: Start sampled at edge 0 -> Done high in cycle 33 (at edge 1 for divide-by-zero).
REQ-020 Multiply result: {Hi,Lo} SHALL equal the signed 64-bit two's-complement product of A and B.
REQ-021 Divide result: Lo SHALL equal the quotient truncated toward zero; Hi SHALL equal the remainder, carrying the sign of the dividend.
REQ-022 Divide 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000 and Hi=0x00000000, with no flag.
REQ-023 Start while Busy=1 SHALL be ignored; the in-flight operation and its captured operands SHALL be unaffected.
REQ-024 A, B and MultOrDiv changing after capture SHALL not affect the result.
REQ-025 ErroDiv SHALL assert on the same cycle as Done and hold until the next accepted Start or reset.
REQ-026 Start arriving in the same cycle as Done SHALL be ignored (FINISH is not IDLE); it is accepted from the following cycle.
REQ-027 Busy SHALL be a decode of state != IDLE; Done SHALL be a decode of state == FINISH.

Reset
REQ-028 reset=0 SHALL immediately force state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, ErroDiv=0, and clear the counter and operand registers.
REQ-029 Reset asserted mid-operation SHALL abort the operation, with no Done pulse and no Hi/Lo update.
REQ-030 After reset deasserts, the first rising edge SHALL accept Start normally.

Verification
REQ-031 Multiply A=7, B=0xFFFFFFFD -> Done in cycle 33 with Hi=0xFFFFFFFF and Lo=0xFFFFFFEB; Busy high in cycles 1-33.
REQ-032 Multiply A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
REQ-033 Divide A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); divide A=7, B=0xFFFFFFFE -> Lo=0xFFFFFFFD, Hi=1.
REQ-034 Divide A=5, B=0 with prior Hi/Lo=0x11/0x22 -> Done and ErroDiv at cycle 1, Hi/Lo still 0x11/0x22, ErroDiv still high 5 cycles later.
REQ-035 Start a multiply, pulse Start with new operands at cycle 10, then pull reset low at cycle 20 -> no Done; all outputs zero; a fresh multiply 3*4 after release gives Lo=12, Hi=0.
REQ-036 Divide 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0, ErroDiv=0.
